// File: rtl/usb_fs_tx_serializer.sv
// Full-speed USB transmit bit engine: SYNC, LSB-first data, bit stuffing, NRZI, EOP.
// One line symbol per bit_tick; tx_ready is combinational at each byte slot.
module usb_fs_tx_serializer #(
    parameter logic [7:0]  SYNC_PATTERN = 8'h80,
    parameter int unsigned STUFF_LEN    = 6,
    parameter int unsigned EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_tick,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       usb_dp,
    output logic       usb_dm,
    output logic       usb_oe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int unsigned   OW       = $clog2(STUFF_LEN + 1);
    localparam int unsigned   EW       = $clog2(EOP_SE0_BITS + 1);
    localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
    localparam logic [EW-1:0] SE0_MAX  = EW'(EOP_SE0_BITS);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J} state_t;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [OW-1:0] ones_q, ones_d;
    logic [EW-1:0] se0_cnt_q, se0_cnt_d;
    logic [7:1]    shift_q, shift_d;
    logic          last_q, last_d;
    logic          dp_q, dp_d, dm_q, dm_d, oe_q, oe_d;
    logic          busy_q, busy_d, done_q, done_d, und_q, und_d;
    logic          stuff_due, slot, emit_vld, emit_val, eop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            se0_cnt_q <= '0;
            shift_q   <= '0;
            last_q    <= 1'b0;
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            und_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            se0_cnt_q <= se0_cnt_d;
            shift_q   <= shift_d;
            last_q    <= last_d;
            dp_q      <= dp_d;
            dm_q      <= dm_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            und_q     <= und_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        se0_cnt_d = se0_cnt_q;
        shift_d   = shift_q;
        last_d    = last_q;
        dp_d      = dp_q;
        dm_d      = dm_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        und_d     = 1'b0;
        emit_vld  = 1'b0;
        emit_val  = 1'b0;
        eop       = 1'b0;
        if (bit_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (tx_valid) begin
                        state_d   = S_SYNC;
                        oe_d      = 1'b1;
                        busy_d    = 1'b1;
                        last_d    = 1'b0;
                        bit_cnt_d = 3'd1;
                        emit_vld  = 1'b1;
                        emit_val  = SYNC_PATTERN[0];
                    end
                end
                S_SYNC: begin
                    emit_vld = 1'b1;
                    if (!stuff_due) begin
                        emit_val  = SYNC_PATTERN[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    // A due stuff bit always wins; the pending data bit or slot waits a tick.
                    if (stuff_due) begin
                        emit_vld = 1'b1;
                    end else if (bit_cnt_q == 3'd0) begin
                        if (last_q) begin
                            eop = 1'b1;
                        end else if (tx_valid) begin
                            emit_vld  = 1'b1;
                            emit_val  = tx_data[0];
                            shift_d   = tx_data[7:1];
                            last_d    = tx_last;
                            bit_cnt_d = 3'd1;
                        end else begin
                            und_d = 1'b1;
                            eop   = 1'b1;
                        end
                    end else begin
                        emit_vld  = 1'b1;
                        emit_val  = shift_q[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                S_EOP_SE0: begin
                    if (se0_cnt_q == SE0_MAX) begin
                        state_d = S_EOP_J;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
                    end else begin
                        se0_cnt_d = se0_cnt_q + EW'(1);
                    end
                end
                S_EOP_J: begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
            if (eop) begin
                state_d   = S_EOP_SE0;
                dp_d      = 1'b0;
                dm_d      = 1'b0;
                se0_cnt_d = EW'(1);
                ones_d    = '0;
                bit_cnt_d = 3'd0;
            end
            // NRZI: a 0 toggles J<->K, a 1 holds the line.
            if (emit_vld) begin
                if (emit_val) begin
                    ones_d = ones_q + OW'(1);
                end else begin
                    dp_d   = ~dp_q;
                    dm_d   = dp_q;
                    ones_d = '0;
                end
            end
        end
    end

    always_comb begin
        stuff_due = (ones_q == ONES_MAX);
        slot      = (state_q == S_DATA) && (bit_cnt_q == 3'd0) && !last_q;
        tx_ready  = bit_tick && slot && !stuff_due;
    end

    assign usb_dp   = dp_q;
    assign usb_dm   = dm_q;
    assign usb_oe   = oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = und_q;

endmodule

// File: tb/tb_usb_fs_tx_serializer.sv
// Directed bench for usb_fs_tx_serializer: a per-tick symbol scoreboard is built
// from an independent reference of the USB bit stream and compared tick by tick.
module tb_usb_fs_tx_serializer;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [6:0] exp_t;   // {dp, dm, oe, busy, accepted, underrun, done}

    logic       clk = 1'b0;
    logic       rst, bit_tick, tx_valid, tx_last;
    logic [7:0] tx_data;
    logic       tx_ready, usb_dp, usb_dm, usb_oe, busy, done, underrun;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    byte_q_t pkt;

    usb_fs_tx_serializer dut (
        .clk(clk), .rst(rst), .bit_tick(bit_tick), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .usb_dp(usb_dp), .usb_dm(usb_dm), .usb_oe(usb_oe),
        .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input exp_t obs, input exp_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_bit(input logic v, input logic acc, inout logic line, inout int ones);
        if (v) ones++;
        else begin
            line = ~line;
            ones = 0;
        end
        exp_q.push_back({line, ~line, 1'b1, 1'b1, acc, 1'b0, 1'b0});
    endtask

    // Reference stream: SYNC + bytes LSB-first, a 0 after every 6 ones, NRZI from J, then EOP.
    task automatic build(input byte_q_t b, input bit trunc);
        logic       line;
        int         ones;
        logic [7:0] sp;
        line = 1'b1;
        ones = 0;
        sp   = 8'h80;
        for (int i = 0; i < 8; i++) push_bit(sp[i], 1'b0, line, ones);
        for (int i = 0; i < b.size(); i++) begin
            for (int k = 0; k < 8; k++) begin
                if (ones == 6) push_bit(1'b0, 1'b0, line, ones);
                push_bit(b[i][k], k == 0, line, ones);
            end
        end
        if (ones == 6) push_bit(1'b0, 1'b0, line, ones);
        exp_q.push_back({2'b00, 1'b1, 1'b1, 1'b0, trunc, 1'b0});
        exp_q.push_back({2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    // Drives a packet with one bit_tick every 4 clocks. max_ticks=0 runs to done.
    task automatic send(input string name, input byte_q_t b, input bit trunc,
                        input bit hold, input int max_ticks);
        int   idx;
        int   n;
        logic acc;
        exp_t e;
        build(b, trunc);
        idx      = 0;
        tx_data  = b[0];
        tx_last  = (b.size() == 1) && !trunc;
        tx_valid = 1'b1;
        n = exp_q.size();
        if (max_ticks > 0 && max_ticks < n) n = max_ticks;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            chk($sformatf("%s_pulse_clear%0d", name, t), {5'b0, done, underrun}, 7'b0);
            repeat (2) @(negedge clk);
            bit_tick = 1'b1;
            #1;
            acc = tx_ready & tx_valid;
            @(negedge clk);
            bit_tick = 1'b0;
            e = exp_q.pop_front();
            chk($sformatf("%s_tick%0d", name, t + 1),
                {usb_dp, usb_dm, usb_oe, busy, acc, underrun, done}, e);
            if (acc) begin
                idx++;
                if (idx < b.size()) begin
                    tx_data = b[idx];
                    tx_last = (idx == b.size() - 1) && !trunc;
                end else begin
                    tx_valid = hold;
                    tx_last  = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        bit_tick = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {usb_dp, usb_dm, usb_oe, busy, tx_ready, underrun, done}, 7'b1000000);
        rst = 1'b0;

        // No bit_tick with data offered: nothing moves.
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tx_last  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("no_tick%0d", i), {2'b0, usb_dp, usb_dm, usb_oe, busy, tx_ready}, 7'b0010000);
        end

        pkt = {8'hFF};
        send("ff", pkt, 1'b0, 1'b0, 0);
        pkt = {8'hA5, 8'h3C};
        send("a5_3c", pkt, 1'b0, 1'b1, 0);      // tx_valid stays high across the done tick
        pkt = {8'h7E, 8'hFC, 8'hFF};
        send("stuff_cross", pkt, 1'b0, 1'b0, 0);
        pkt = {8'hFC};
        send("stuff_tail", pkt, 1'b0, 1'b0, 0);
        pkt = {8'hA5};
        send("underrun", pkt, 1'b1, 1'b0, 0);
        pkt = {8'hFC};
        send("underrun_stuff", pkt, 1'b1, 1'b0, 0);

        // Reset while DATA bit 3 is on the line.
        pkt = {8'hA5, 8'h3C};
        send("pre_rst", pkt, 1'b0, 1'b0, 12);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset", {3'b0, usb_dp, usb_dm, usb_oe, busy}, 7'b0001000);
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        exp_q.delete();
        pkt = {8'hFF};
        send("after_rst", pkt, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
